// File: rtl/object_motion_engine.sv
// Single-sprite motion engine: per-axis tick counters, wall bounce with clamp,
// load/run/pause FSM and kick-to-flip-dy. Optional gravity via OBJECT_MOTION_GRAVITY_EN.
module object_motion_engine #(
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int PER_W   = 32,
    parameter int STEP    = 1,
    parameter int FIELD_W = 640,
    parameter int FIELD_H = 480
`ifdef OBJECT_MOTION_GRAVITY_EN
    ,
    parameter int GRAV_DIV = 8
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef OBJECT_MOTION_GRAVITY_EN
    input  logic [PER_W-1:0] ty_min,
`endif
    input  logic             load,
    input  logic             pause,
    input  logic             stop,
    input  logic             kick,
    input  logic [X_W-1:0]   obj_w,
    input  logic [Y_W-1:0]   obj_h,
    input  logic [X_W-1:0]   init_x,
    input  logic [Y_W-1:0]   init_y,
    input  logic             init_dx,
    input  logic             init_dy,
    input  logic [PER_W-1:0] per_x,
    input  logic [PER_W-1:0] per_y,
    output logic [X_W-1:0]   posx,
    output logic [Y_W-1:0]   posy,
    output logic             dx,
    output logic             dy,
    output logic             running,
    output logic             bounce_x,
    output logic             bounce_y
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2} state_t;

    localparam logic [X_W:0]          FW = (X_W+1)'(FIELD_W);
    localparam logic [Y_W:0]          FH = (Y_W+1)'(FIELD_H);
    localparam logic signed [X_W+1:0] SX = (X_W+2)'(STEP);
    localparam logic signed [Y_W+1:0] SY = (Y_W+2)'(STEP);

    state_t           state, state_nxt;
    logic [X_W:0]     xmax;
    logic [Y_W:0]     ymax;
    logic [PER_W-1:0] cnt_x, cnt_y, per_x_q, per_y_q;
    logic             kick_q, kick_edge, move_en, step_x, step_y;

    logic signed [X_W+1:0] xn;
    logic signed [Y_W+1:0] yn;
    logic [X_W-1:0]        x_nxt;
    logic [Y_W-1:0]        y_nxt;
    logic                  dx_nxt, dy_nxt, hit_x, hit_y;

`ifdef OBJECT_MOTION_GRAVITY_EN
    localparam int GW = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
    logic [GW-1:0] grav_cnt;
`endif

    // Limits follow obj_w/obj_h live; oversize sprites pin the limit at 0.
    assign xmax = ({1'b0, obj_w} >= FW) ? '0 : FW - {1'b0, obj_w};
    assign ymax = ({1'b0, obj_h} >= FH) ? '0 : FH - {1'b0, obj_h};

    assign kick_edge = kick & ~kick_q;
    assign move_en   = (state == RUN) && !pause && !stop && !load;
    assign step_x    = move_en && (per_x_q != '0) && (cnt_x >= per_x_q - PER_W'(1));
    assign step_y    = move_en && (per_y_q != '0) && (cnt_y >= per_y_q - PER_W'(1));
    assign running   = (state != IDLE);

    always_comb begin
        state_nxt = state;
        if (load)
            state_nxt = RUN;
        else if (stop)
            state_nxt = IDLE;
        else begin
            case (state)
                RUN:     if (pause)  state_nxt = PAUSED;
                PAUSED:  if (!pause) state_nxt = RUN;
                default: state_nxt = state;
            endcase
        end
    end

    // Over-max covers both the normal +dir hit and a limit that shrank under
    // the sprite; either way the sprite is clamped and sent away from the wall.
    always_comb begin
        xn     = dx ? $signed({2'b00, posx}) + SX : $signed({2'b00, posx}) - SX;
        x_nxt  = xn[X_W-1:0];
        dx_nxt = dx;
        hit_x  = 1'b0;
        if (xn > $signed({1'b0, xmax})) begin
            x_nxt  = xmax[X_W-1:0];
            dx_nxt = 1'b0;
            hit_x  = 1'b1;
        end else if (xn[X_W+1]) begin
            x_nxt  = '0;
            dx_nxt = 1'b1;
            hit_x  = 1'b1;
        end
    end

    always_comb begin
        yn     = dy ? $signed({2'b00, posy}) + SY : $signed({2'b00, posy}) - SY;
        y_nxt  = yn[Y_W-1:0];
        dy_nxt = dy;
        hit_y  = 1'b0;
        if (yn > $signed({1'b0, ymax})) begin
            y_nxt  = ymax[Y_W-1:0];
            dy_nxt = 1'b0;
            hit_y  = 1'b1;
        end else if (yn[Y_W+1]) begin
            y_nxt  = '0;
            dy_nxt = 1'b1;
            hit_y  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            posx     <= '0;
            posy     <= '0;
            dx       <= 1'b0;
            dy       <= 1'b0;
            cnt_x    <= '0;
            cnt_y    <= '0;
            per_x_q  <= '0;
            per_y_q  <= '0;
            kick_q   <= 1'b0;
            bounce_x <= 1'b0;
            bounce_y <= 1'b0;
`ifdef OBJECT_MOTION_GRAVITY_EN
            grav_cnt <= '0;
`endif
        end else begin
            state    <= state_nxt;
            kick_q   <= kick;
            bounce_x <= 1'b0;
            bounce_y <= 1'b0;
            if (load) begin
                posx    <= init_x;
                posy    <= init_y;
                dx      <= init_dx;
                dy      <= init_dy;
                per_x_q <= per_x;
                per_y_q <= per_y;
                cnt_x   <= '0;
                cnt_y   <= '0;
`ifdef OBJECT_MOTION_GRAVITY_EN
                grav_cnt <= '0;
`endif
            end else begin
                if (step_x) begin
                    cnt_x <= '0;
                    posx  <= x_nxt;
                    dx    <= dx_nxt;
                    bounce_x <= hit_x;
                end else if (move_en && per_x_q != '0)
                    cnt_x <= cnt_x + PER_W'(1);

                if (step_y) begin
                    cnt_y <= '0;
                    posy  <= y_nxt;
                    bounce_y <= hit_y;
`ifdef OBJECT_MOTION_GRAVITY_EN
                    // Rising sprites slow down, falling ones speed up.
                    if (grav_cnt == GW'(GRAV_DIV - 1)) begin
                        grav_cnt <= '0;
                        if (!dy) begin
                            if (per_y_q != '1) per_y_q <= per_y_q + PER_W'(1);
                        end else if (per_y_q > ty_min)
                            per_y_q <= per_y_q - PER_W'(1);
                    end else
                        grav_cnt <= grav_cnt + GW'(1);
`endif
                end else if (move_en && per_y_q != '0)
                    cnt_y <= cnt_y + PER_W'(1);

                // A wall reflection outranks a coincident kick.
                if (step_y && hit_y)
                    dy <= dy_nxt;
                else if (kick_edge && state != IDLE)
                    dy <= ~dy;
            end
        end
    end

endmodule

// File: tb/tb_object_motion_engine.sv
// Scoreboard bench for object_motion_engine: directed scenarios plus random
// traffic, each cycle checked against a behavioural sprite model.
module tb_object_motion_engine;
    localparam int X_W = 10, Y_W = 9, PER_W = 32, STEP = 1, FW = 640, FH = 480;

    logic clk = 1'b0, rst_n = 1'b0;
    logic load = 1'b0, pause = 1'b0, stop = 1'b0, kick = 1'b0;
    logic [X_W-1:0] obj_w = 10'd40, init_x = '0;
    logic [Y_W-1:0] obj_h = 9'd30, init_y = '0;
    logic init_dx = 1'b0, init_dy = 1'b0;
    logic [PER_W-1:0] per_x = '0, per_y = '0;
    logic [X_W-1:0] posx;
    logic [Y_W-1:0] posy;
    logic dx, dy, running, bounce_x, bounce_y;

    object_motion_engine #(.X_W(X_W), .Y_W(Y_W), .PER_W(PER_W), .STEP(STEP),
                           .FIELD_W(FW), .FIELD_H(FH)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .pause(pause), .stop(stop), .kick(kick),
        .obj_w(obj_w), .obj_h(obj_h), .init_x(init_x), .init_y(init_y),
        .init_dx(init_dx), .init_dy(init_dy), .per_x(per_x), .per_y(per_y),
        .posx(posx), .posy(posy), .dx(dx), .dy(dy), .running(running),
        .bounce_x(bounce_x), .bounce_y(bounce_y));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic dx, dy, run, bx, by;
    } obs_t;

    obs_t sb[$];
    obs_t mon_e;
    int checks = 0, failures = 0;

    // Model: st 0=idle 1=run 2=paused
    int m_st, m_x, m_y, m_dx, m_dy, m_cx, m_cy, m_px, m_py, m_kq, m_bx, m_by;

    function automatic obs_t cur();
        return '{posx, posy, dx, dy, running, bounce_x, bounce_y};
    endfunction

    function automatic obs_t model_obs();
        return '{X_W'(m_x), Y_W'(m_y), 1'(m_dx), 1'(m_dy), (m_st != 0), 1'(m_bx), 1'(m_by)};
    endfunction

    task automatic chk(input string nm, input obs_t g, input obs_t e);
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL %s got x=%0d y=%0d dx=%0b dy=%0b run=%0b bx=%0b by=%0b want x=%0d y=%0d dx=%0b dy=%0b run=%0b bx=%0b by=%0b t=%0t",
                     nm, g.x, g.y, g.dx, g.dy, g.run, g.bx, g.by, e.x, e.y, e.dx, e.dy, e.run, e.bx, e.by, $time);
        end
    endtask

    task automatic chk_v(input string nm, input int g, input int e);
        checks++;
        if (g != e) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, g, e, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_x = 0; m_y = 0; m_dx = 0; m_dy = 0; m_cx = 0; m_cy = 0;
        m_px = 0; m_py = 0; m_kq = 0; m_bx = 0; m_by = 0;
    endtask

    // One pixel step with wall reflection; over-limit always heads back toward 0.
    task automatic axis(inout int p, inout int d, output int hit, input int mx);
        int n;
        n = p + (d != 0 ? STEP : -STEP);
        hit = 0;
        if (n > mx) begin p = mx; d = 0; hit = 1; end
        else if (n < 0) begin p = 0; d = 1; hit = 1; end
        else p = n;
    endtask

    task automatic model_step();
        int mv, edge_k, xmax, ymax;
        if (!rst_n) model_reset();
        else begin
            mv = (m_st == 1 && !pause && !stop && !load);
            edge_k = (kick && m_kq == 0);
            m_bx = 0; m_by = 0;
            if (load) begin
                m_st = 1; m_x = init_x; m_y = init_y; m_dx = init_dx; m_dy = init_dy;
                m_px = int'(per_x); m_py = int'(per_y); m_cx = 0; m_cy = 0;
            end else begin
                if (mv) begin
                    xmax = (int'(obj_w) >= FW) ? 0 : FW - int'(obj_w);
                    ymax = (int'(obj_h) >= FH) ? 0 : FH - int'(obj_h);
                    if (m_px != 0) begin
                        if (m_cx == m_px - 1) begin m_cx = 0; axis(m_x, m_dx, m_bx, xmax); end
                        else m_cx++;
                    end
                    if (m_py != 0) begin
                        if (m_cy == m_py - 1) begin m_cy = 0; axis(m_y, m_dy, m_by, ymax); end
                        else m_cy++;
                    end
                end
                if (edge_k && m_st != 0 && m_by == 0) m_dy = 1 - m_dy;
                if (stop) m_st = 0;
                else if (m_st == 1 && pause) m_st = 2;
                else if (m_st == 2 && !pause) m_st = 1;
            end
            m_kq = kick;
        end
    endtask

    task automatic cyc();
        model_step();
        sb.push_back(model_obs());
        @(posedge clk);
        #1;
        load = 1'b0;
        stop = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 model_reset();
        chk("async_reset", cur(), obs_t'(0));
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic do_load(input int x, input int y, input int ddx, input int ddy,
                           input int px, input int py);
        init_x = X_W'(x); init_y = Y_W'(y); init_dx = 1'(ddx); init_dy = 1'(ddy);
        per_x = PER_W'(px); per_y = PER_W'(py);
        load = 1'b1;
        cyc();
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("sb", cur(), mon_e);
        end
    end

    initial begin
        model_reset();
        repeat (2) cyc();
        chk("reset_state", cur(), obs_t'(0));
        rst_n = 1'b1;
        cyc();

        // Slow x tick, y stationary
        do_load(100, 50, 1, 0, 4, 0);
        repeat (4) cyc();
        chk_v("x_first_step", int'(posx), 101);
        repeat (96) cyc();
        chk_v("x_after_100", int'(posx), 125);
        chk_v("y_stationary", int'(posy), 50);
        do_reset();

        // Right wall
        do_load(598, 50, 1, 0, 1, 0);
        cyc();
        chk_v("x_599", int'(posx), 599);
        cyc();
        chk_v("x_600_no_bounce", int'(bounce_x), 0);
        cyc();
        chk_v("x_clamp", int'(posx), 600);
        chk_v("dx_flip", int'(dx), 0);
        chk_v("bounce_x", int'(bounce_x), 1);
        cyc();
        chk_v("x_back_599", int'(posx), 599);
        chk_v("bounce_x_clear", int'(bounce_x), 0);

        // Corner
        do_load(600, 450, 1, 1, 2, 2);
        repeat (2) cyc();
        chk_v("corner_bx", int'(bounce_x), 1);
        chk_v("corner_by", int'(bounce_y), 1);
        chk_v("corner_dxdy", int'({dx, dy}), 0);

        // Kick
        do_load(300, 200, 0, 1, 0, 3);
        kick = 1'b1;
        cyc();
        chk_v("kick_flip", int'(dy), 0);
        repeat (10) cyc();
        chk_v("kick_held", int'(dy), 0);
        kick = 1'b0;
        cyc();
        do_load(300, 0, 0, 0, 0, 1);
        kick = 1'b1;
        cyc();
        chk_v("kick_vs_bounce_dy", int'(dy), 1);
        chk_v("kick_vs_bounce_by", int'(bounce_y), 1);
        chk_v("kick_vs_bounce_y", int'(posy), 0);
        kick = 1'b0;
        cyc();

        // Pause resumes at remaining count
        do_load(100, 100, 1, 1, 5, 7);
        repeat (7) cyc();
        pause = 1'b1;
        repeat (20) cyc();
        chk_v("pause_x", int'(posx), 101);
        chk_v("pause_y", int'(posy), 101);
        chk_v("pause_running", int'(running), 1);
        pause = 1'b0;
        repeat (3) cyc();
        chk_v("resume_x_hold", int'(posx), 101);
        cyc();
        chk_v("resume_x_step", int'(posx), 102);
        stop = 1'b1;
        cyc();
        chk_v("stop_running", int'(running), 0);
        repeat (5) cyc();
        chk_v("stop_hold_x", int'(posx), 102);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 799) == 0) do_reset();
            if (i == 0 || $urandom_range(0, 49) == 0) begin
                init_x  = X_W'($urandom_range(0, 639));
                init_y  = Y_W'($urandom_range(0, 479));
                init_dx = 1'($urandom_range(0, 1));
                init_dy = 1'($urandom_range(0, 1));
                per_x   = PER_W'($urandom_range(0, 4));
                per_y   = PER_W'($urandom_range(0, 4));
                load    = 1'b1;
            end
            if ($urandom_range(0, 149) == 0) stop = 1'b1;
            if ($urandom_range(0, 24) == 0) pause = ~pause;
            if ($urandom_range(0, 5) == 0) kick = ~kick;
            if ($urandom_range(0, 249) == 0) begin
                obj_w = X_W'($urandom_range(0, 700));
                obj_h = Y_W'($urandom_range(0, 511));
            end
            cyc();
        end

        #20;
        chk_v("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/object_motion_engine.md
Name: object_motion_engine

Overview:
- Parametrised successor to the single-object motion block: moves one sprite across a bounded playfield at independent per-axis tick rates.
- Handles edge bounce on both axes in the same cycle, with clamping and a configurable pixel step.
- Adds a load/run/pause control FSM, an edge-detected "kick" input that reverses vertical direction, and per-axis bounce strobes for the scoring and sound logic.
- Instantiated once per fruit/bomb sprite. Its outputs feed the VGA sprite renderer and the slice detector.

Parameters:
X_W, 10, width of posx and of the playfield/sprite width values
Y_W, 9, width of posy and of the height values
PER_W, 32, width of the per-axis tick period
STEP, 1, pixels moved per axis tick (1..7)
FIELD_W, 640, playfield width in pixels
FIELD_H, 480, playfield height in pixels

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load  in  1  one-cycle pulse: capture init_x/init_y/init_dx/init_dy/per_x/per_y and enter RUN
pause  in  1  level: freeze motion while high
stop  in  1  one-cycle pulse: return to IDLE
kick  in  1  level input; each rising edge flips dy
obj_w  in  X_W  sprite width
obj_h  in  Y_W  sprite height
init_x  in  X_W  initial x
init_y  in  Y_W  initial y
init_dx  in  1  initial x direction (1 = +x)
init_dy  in  1  initial y direction (1 = +y, i.e. down)
per_x  in  PER_W  clocks per x step; 0 = x axis stationary
per_y  in  PER_W  clocks per y step; 0 = y axis stationary
posx  out  X_W  current x (top-left corner)
posy  out  Y_W  current y
dx  out  1  current x direction
dy  out  1  current y direction
running  out  1  high in RUN or PAUSED
bounce_x  out  1  one-cycle strobe on an x-wall reflection
bounce_y  out  1  one-cycle strobe on a y-wall reflection

Behaviour:
- Clock is clk; reset is rst_n, asynchronous and active-low.
- Reset state: state=IDLE, posx=0, posy=0, dx=0, dy=0, counters=0, kick edge register=0, running=0, bounce_x=0, bounce_y=0.
- FSM states:
  - IDLE: positions hold.
  - load -> RUN, registering all init_* values and both periods in the same edge; posx/posy show init values on the next cycle.
  - RUN: pause=1 -> PAUSED; stop -> IDLE.
  - PAUSED: pause=0 -> RUN; stop -> IDLE.
  - load in any state reloads everything and enters RUN. load has priority over stop, and stop has priority over pause.
- Limits: XMAX = FIELD_W - obj_w and YMAX = FIELD_H - obj_h, computed at X_W+1 / Y_W+1 bits. If obj_w >= FIELD_W, XMAX=0; same rule for YMAX.
- Per-axis counter (RUN only):
  - Increments every clock. When it reaches per-1 it clears and the axis steps STEP pixels in its direction.
  - per=0: counter and axis frozen. per=1: step every clock.
  - Counters hold in PAUSED and clear on load.
- Step arithmetic is done in signed width+2 bits:
  - If the +direction step would exceed the max: pos=max, direction flips, strobe for 1 cycle.
  - If the -direction step would go below 0: pos=0, direction flips, strobe.
  - A step landing exactly on 0 or max does not bounce; the bounce happens on the next step of that axis.
  - The x and y axes are independent; a corner hit asserts both strobes in the same cycle.
- Kick:
  - kick is registered once per clock; rising edge = kick & ~kick_q. A rising edge in RUN or PAUSED flips dy. Edges in IDLE are ignored.
  - If a kick edge and a y bounce occur in the same cycle, the bounce direction wins (away from the wall) and the kick is dropped.
- Mid-run changes: obj_w/obj_h are used live. If the limits shrink below the current position, the next step on that axis clamps to max and bounces.
- Async reset mid-motion: all outputs take reset values immediately.

Optional Feature:
- Macro: OBJECT_MOTION_GRAVITY_EN.
- When defined:
  - Adds parameter GRAV_DIV (default 8) and port ty_min (in, PER_W).
  - Every GRAV_DIV y-steps the live y period is adjusted: +1 while dy=0 (rising, slowing); -1 while dy=1 (falling, speeding up).
  - The live y period never drops below ty_min and never wraps past the maximum.
  - The live period reloads from per_y on load.
- When not defined: the y period is constant, and there is no GRAV_DIV and no ty_min port.

Test Plan:
- Reset with clk running -> posx=0, posy=0, running=0, no strobes; rst_n asserted mid-RUN -> immediate return to these values.
- load init_x=100, init_y=50, init_dx=1, init_dy=0, per_x=4, per_y=0, STEP=1 -> posx=101 four clocks after RUN entry, 125 after 100 clocks; posy stays 50.
- obj_w=40, init_x=598, init_dx=1, per_x=1, STEP=1 -> posx 599, 600, then the next step clamps to 600 with dx=0 and one bounce_x pulse, then 599.
- Corner: obj_w=40, obj_h=30, init_x=600, init_y=450, both directions 1, per_x=per_y=2 -> bounce_x and bounce_y asserted in the same cycle, dx=dy=0.
- kick rising edge in RUN with dy=1 -> dy=0 next cycle; kick held high 10 cycles -> a single flip; kick edge coincident with a y bounce at posy=0 -> dy=1.
- pause high for 20 clocks mid-RUN -> posx/posy frozen and counters held; after release the first step occurs at the remaining count. stop -> IDLE with position held and running=0.
